// File: rtl/usr_seq_ctrl.sv
// Command sequencer for a universal shift register: applies a USR mode for a
// requested number of cycles and reports completion with a done pulse.
module usr_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic [1:0]       shf_o,
  output logic [WIDTH-1:0] a_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o
);

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [1:0]       shf_n;
  logic [WIDTH-1:0] a_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             aborted_n;

  // State and output registers; status flags are decoded from the next state
  // so they are registered yet still track the state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shf_o     <= OP_HOLD;
      a_o       <= '0;
      cnt       <= '0;
      done_o    <= 1'b0;
      aborted_o <= 1'b0;
      busy_o    <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_n;
      shf_o     <= shf_n;
      a_o       <= a_n;
      cnt       <= cnt_n;
      done_o    <= (state_n == DONE);
      aborted_o <= aborted_n;
      busy_o    <= (state_n != IDLE);
      cmd_ready <= (state_n == IDLE);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    shf_n     = shf_o;
    a_n       = a_o;
    cnt_n     = cnt;
    aborted_n = 1'b0;
    case (state)
      IDLE: begin
        shf_n = OP_HOLD;
        if (cmd_valid) begin
          if (cmd_op == OP_LOAD) begin
            a_n     = cmd_data;
            shf_n   = OP_LOAD;
            cnt_n   = '0;
            state_n = RUN;
          end else if (cmd_cnt != '0) begin
            shf_n   = cmd_op;
            cnt_n   = cmd_cnt - CNT_W'(1);
            state_n = RUN;
          end else begin
            state_n = DONE;
          end
        end
      end
      RUN: begin
        if (abort) begin
          // Abort wins even on the natural last cycle.
          shf_n     = OP_HOLD;
          cnt_n     = '0;
          aborted_n = 1'b1;
          state_n   = DONE;
        end else if (cnt == '0) begin
          shf_n   = OP_HOLD;
          state_n = DONE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        shf_n   = OP_HOLD;
        state_n = IDLE;
      end
      default: begin
        shf_n   = OP_HOLD;
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Directed self-checking bench for usr_seq_ctrl with a reference USR model.
module tb_usr_seq_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_cnt = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             abort = 1'b0;
  logic [1:0]       shf_o;
  logic [WIDTH-1:0] a_o;
  logic             busy_o;
  logic             done_o;
  logic             aborted_o;
  logic [WIDTH-1:0] y;

  int total = 0;
  int bad = 0;

  usr_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .abort(abort),
    .shf_o(shf_o), .a_o(a_o), .busy_o(busy_o), .done_o(done_o),
    .aborted_o(aborted_o)
  );

  always #5 clk = ~clk;

  // Downstream USR driven by the controller outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y <= '0;
    else begin
      case (shf_o)
        2'b01:   y <= {y[WIDTH-2:0], 1'b0};
        2'b10:   y <= {1'b0, y[WIDTH-1:1]};
        2'b11:   y <= a_o;
        default: y <= y;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE and follow it to its done pulse.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                         input logic [WIDTH-1:0] data, input int exp_n, input logic [WIDTH-1:0] exp_y);
    int n;
    int wrong;
    n = 0;
    wrong = 0;
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; cmd_data = data;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !done_o; i++) begin
      if (shf_o !== op) wrong++;
      n++;
      tick();
    end
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    chk({tag, "_ncyc"}, 32'(n), 32'(exp_n));
    chk({tag, "_shfop"}, 32'(wrong), 32'd0);
    chk({tag, "_shf0"}, 32'(shf_o), 32'd0);
    chk({tag, "_abt"}, 32'(aborted_o), 32'd0);
    chk({tag, "_rdy0"}, 32'(cmd_ready), 32'd0);
    tick();
    chk({tag, "_done1"}, 32'(done_o), 32'd0);
    chk({tag, "_rdy1"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_y"}, 32'(y), 32'(exp_y));
  endtask

  initial begin
    // Asynchronous reset effect before any clock edge.
    #4;
    chk("rst_shf", 32'(shf_o), 32'd0);
    chk("rst_a", 32'(a_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_abt", 32'(aborted_o), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Load, then detailed look at the load cycle.
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 4'b1011; cmd_cnt = 3'd5;
    tick();
    cmd_valid = 1'b0;
    chk("ld_shf", 32'(shf_o), 32'd3);
    chk("ld_a", 32'(a_o), 32'hb);
    chk("ld_busy", 32'(busy_o), 32'd1);
    chk("ld_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("ld_done", 32'(done_o), 32'd1);
    chk("ld_shf0", 32'(shf_o), 32'd0);
    chk("ld_y", 32'(y), 32'hb);
    tick();
    chk("ld_done1", 32'(done_o), 32'd0);

    run_cmd("shl2", 2'b01, 3'd2, 4'b1111, 2, 4'b1100);
    run_cmd("shr3", 2'b10, 3'd3, 4'b1111, 3, 4'b0001);
    run_cmd("shr0", 2'b10, 3'd0, 4'b1111, 0, 4'b0001);
    run_cmd("dly4", 2'b00, 3'd4, 4'b1111, 4, 4'b0001);
    chk("dly_a", 32'(a_o), 32'hb);

    // Abort on the third RUN cycle of a 7-cycle shift left.
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_cnt = 3'd7;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    chk("ab_shf_run", 32'(shf_o), 32'd1);
    tick();
    abort = 1'b0;
    chk("ab_shf", 32'(shf_o), 32'd0);
    chk("ab_done", 32'(done_o), 32'd1);
    chk("ab_abt", 32'(aborted_o), 32'd1);
    chk("ab_y", 32'(y), 32'h8);
    tick();
    chk("ab_done1", 32'(done_o), 32'd0);
    chk("ab_abt1", 32'(aborted_o), 32'd0);

    // Abort in IDLE does nothing.
    abort = 1'b1;
    tick(); tick();
    chk("abi_busy", 32'(busy_o), 32'd0);
    chk("abi_done", 32'(done_o), 32'd0);
    chk("abi_abt", 32'(aborted_o), 32'd0);

    // Abort together with cmd_valid in IDLE: command accepted.
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 4'b0101;
    tick();
    cmd_valid = 1'b0; abort = 1'b0;
    chk("abv_shf", 32'(shf_o), 32'd3);
    chk("abv_a", 32'(a_o), 32'h5);
    tick();
    chk("abv_done", 32'(done_o), 32'd1);
    chk("abv_abt", 32'(aborted_o), 32'd0);
    chk("abv_y", 32'(y), 32'h5);
    tick();

    // Abort coinciding with the natural last cycle.
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_cnt = 3'd1;
    tick();
    cmd_valid = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abl_done", 32'(done_o), 32'd1);
    chk("abl_abt", 32'(aborted_o), 32'd1);
    chk("abl_y", 32'(y), 32'h2);
    tick();

    // Back-to-back with cmd_valid held high.
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_cnt = 3'd1;
    tick();
    cmd_op = 2'b11; cmd_data = 4'b1111;
    chk("bb_shf1", 32'(shf_o), 32'd1);
    tick();
    cmd_op = 2'b10; cmd_cnt = 3'd2;
    chk("bb_done1", 32'(done_o), 32'd1);
    tick();
    chk("bb_ready", 32'(cmd_ready), 32'd1);
    chk("bb_idle_shf", 32'(shf_o), 32'd0);
    chk("bb_a_keep", 32'(a_o), 32'h5);
    tick();
    cmd_valid = 1'b0;
    chk("bb_shf2", 32'(shf_o), 32'd2);
    chk("bb_busy2", 32'(busy_o), 32'd1);
    tick();
    chk("bb_shf2b", 32'(shf_o), 32'd2);
    tick();
    chk("bb_done2", 32'(done_o), 32'd1);
    chk("bb_y", 32'(y), 32'h1);
    tick();

    // Reset in the middle of a RUN.
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_cnt = 3'd5;
    tick();
    cmd_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_shf", 32'(shf_o), 32'd0);
    chk("mr_busy", 32'(busy_o), 32'd0);
    chk("mr_done", 32'(done_o), 32'd0);
    tick();
    chk("mr_done_edge", 32'(done_o), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mr_ready", 32'(cmd_ready), 32'd1);
    run_cmd("mr_ld", 2'b11, 3'd0, 4'b1001, 1, 4'b1001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
